// File: rtl/ali_dmod_core_if.sv
// AXI4-Lite control channel bundle for the ALI demodulator register bank.
interface ali_dmod_core_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ali_dmod_core.sv
// AXI4-Lite control slave: four 32-bit config registers for the ALI demodulator.
module ali_dmod_core #(
  parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
  parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
  parameter int C_OUT_TDATA_WIDTH          = 64,
  parameter int C_IN_TDATA_WIDTH           = 64,
  parameter int C_TUSER_WIDTH              = 8
) (
  input logic            ap_clk,
  input logic            ap_rst,
  ali_dmod_core_if.slave s_axi_control
);

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2, WR_RST = 2'd3} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_DATA = 2'd1, RD_RST = 2'd2} rd_state_t;

  // Stream widths belong to the datapath; only the control width is constrained here.
  if (C_S_AXI_CONTROL_DATA_WIDTH != 32 || C_S_AXI_CONTROL_ADDR_WIDTH < 12 ||
      C_OUT_TDATA_WIDTH < 1 || C_IN_TDATA_WIDTH < 1 || C_TUSER_WIDTH < 1) begin : g_unsupported_config
  end

  // Word index -> register slot; slot 4 means unmapped.
  function automatic logic [2:0] map_addr(input logic [9:0] idx);
    case (idx)
      10'h004: map_addr = 3'd0;
      10'h006: map_addr = 3'd1;
      10'h008: map_addr = 3'd2;
      10'h00A: map_addr = 3'd3;
      default: map_addr = 3'd4;
    endcase
  endfunction

  wr_state_t         wstate, wnext;
  rd_state_t         rstate, rnext;
  logic [9:0]        aw_idx;
  logic [3:0][31:0]  regs;
  logic [31:0]       rdata_q;
  logic [2:0]        wsel, rsel;
  logic              aw_hs, w_hs, ar_hs;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_control.awaddr[1:0], s_axi_control.araddr[1:0]};

  assign aw_hs = s_axi_control.awvalid & s_axi_control.awready;
  assign w_hs  = s_axi_control.wvalid  & s_axi_control.wready;
  assign ar_hs = s_axi_control.arvalid & s_axi_control.arready;
  assign wsel  = map_addr(aw_idx);
  assign rsel  = map_addr(s_axi_control.araddr[11:2]);

  // Write FSM
  always_ff @(posedge ap_clk) begin
    if (ap_rst) wstate <= WR_RST;
    else        wstate <= wnext;
  end

  always_comb begin
    wnext = wstate;
    case (wstate)
      WR_IDLE: if (s_axi_control.awvalid) wnext = WR_DATA;
      WR_DATA: if (s_axi_control.wvalid)  wnext = WR_RESP;
      WR_RESP: if (s_axi_control.bready)  wnext = WR_IDLE;
      default: wnext = WR_IDLE;
    endcase
  end

  always_comb begin
    s_axi_control.awready = 1'b0;
    s_axi_control.wready  = 1'b0;
    s_axi_control.bvalid  = 1'b0;
    case (wstate)
      WR_IDLE: s_axi_control.awready = 1'b1;
      WR_DATA: s_axi_control.wready  = 1'b1;
      WR_RESP: s_axi_control.bvalid  = 1'b1;
      default: ;
    endcase
  end

  assign s_axi_control.bresp = 2'b00;

  always_ff @(posedge ap_clk) begin
    if (ap_rst)     aw_idx <= '0;
    else if (aw_hs) aw_idx <= s_axi_control.awaddr[11:2];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      regs <= '0;
    end else if (w_hs && !wsel[2]) begin
      for (int b = 0; b < 4; b++)
        if (s_axi_control.wstrb[b]) regs[wsel[1:0]][8*b +: 8] <= s_axi_control.wdata[8*b +: 8];
    end
  end

  // Read FSM
  always_ff @(posedge ap_clk) begin
    if (ap_rst) rstate <= RD_RST;
    else        rstate <= rnext;
  end

  always_comb begin
    rnext = rstate;
    case (rstate)
      RD_IDLE: if (s_axi_control.arvalid) rnext = RD_DATA;
      RD_DATA: if (s_axi_control.rready)  rnext = RD_IDLE;
      default: rnext = RD_IDLE;
    endcase
  end

  always_comb begin
    s_axi_control.arready = (rstate == RD_IDLE);
    s_axi_control.rvalid  = (rstate == RD_DATA);
  end

  // Sampled before any same-edge write lands, so a colliding read sees the old value.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)     rdata_q <= '0;
    else if (ar_hs) rdata_q <= rsel[2] ? 32'h0 : regs[rsel[1:0]];
  end

  assign s_axi_control.rdata = rdata_q;
  assign s_axi_control.rresp = 2'b00;

endmodule

// File: tb/tb_ali_dmod_core.sv
// Directed bench for the ali_dmod_core AXI4-Lite register bank.
module tb_ali_dmod_core;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 ap_clk = ~ap_clk;

  ali_dmod_core_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) axi ();

  ali_dmod_core #(
    .C_S_AXI_CONTROL_ADDR_WIDTH(12),
    .C_S_AXI_CONTROL_DATA_WIDTH(32),
    .C_OUT_TDATA_WIDTH(64),
    .C_IN_TDATA_WIDTH(64),
    .C_TUSER_WIDTH(8)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .s_axi_control(axi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdly);
    int n;
    @(negedge ap_clk);
    chk("wstate_idle", 32'(dut.wstate), 32'd0);
    axi.awaddr  = addr;
    axi.awvalid = 1'b1;
    for (n = 0; n < 20 && axi.awready !== 1'b1; n++) @(negedge ap_clk);
    chk("awready", 32'(axi.awready), 32'd1);
    @(posedge ap_clk); #1 axi.awvalid = 1'b0;
    @(negedge ap_clk);
    chk("wready_after_aw", 32'(axi.wready), 32'd1);
    chk("wstate_data", 32'(dut.wstate), 32'd1);
    chk("bvalid_before_w", 32'(axi.bvalid), 32'd0);
    axi.wdata  = data;
    axi.wstrb  = strb;
    axi.wvalid = 1'b1;
    @(posedge ap_clk); #1 axi.wvalid = 1'b0;
    @(negedge ap_clk);
    chk("bvalid_after_w", 32'(axi.bvalid), 32'd1);
    chk("bresp", 32'(axi.bresp), 32'd0);
    chk("wstate_resp", 32'(dut.wstate), 32'd2);
    chk("wready_after_w", 32'(axi.wready), 32'd0);
    for (n = 0; n < bdly; n++) begin
      @(negedge ap_clk);
      chk("bvalid_held", 32'(axi.bvalid), 32'd1);
    end
    axi.bready = 1'b1;
    @(posedge ap_clk); #1 axi.bready = 1'b0;
    @(negedge ap_clk);
    chk("bvalid_after_b", 32'(axi.bvalid), 32'd0);
    chk("wstate_back_idle", 32'(dut.wstate), 32'd0);
  endtask

  task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp, input int rdly);
    int n;
    @(negedge ap_clk);
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    for (n = 0; n < 20 && axi.arready !== 1'b1; n++) @(negedge ap_clk);
    chk("arready", 32'(axi.arready), 32'd1);
    @(posedge ap_clk); #1 axi.arvalid = 1'b0;
    @(negedge ap_clk);
    chk("rvalid", 32'(axi.rvalid), 32'd1);
    chk("rdata", axi.rdata, exp);
    chk("rresp", 32'(axi.rresp), 32'd0);
    for (n = 0; n < rdly; n++) begin
      @(negedge ap_clk);
      chk("rvalid_held", 32'(axi.rvalid), 32'd1);
      chk("rdata_held", axi.rdata, exp);
    end
    axi.rready = 1'b1;
    @(posedge ap_clk); #1 axi.rready = 1'b0;
    @(negedge ap_clk);
    chk("rvalid_after_r", 32'(axi.rvalid), 32'd0);
    chk("rdata_stable_after_r", axi.rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awvalid = 1'b0; axi.awaddr = '0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0;
    axi.rready  = 1'b0;

    // Long reset, then release
    repeat (200) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_awready", 32'(axi.awready), 32'd0);
    chk("rst_wready",  32'(axi.wready),  32'd0);
    chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
    chk("rst_arready", 32'(axi.arready), 32'd0);
    chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
    chk("rst_bresp",   32'(axi.bresp),   32'd0);
    chk("rst_rresp",   32'(axi.rresp),   32'd0);
    chk("rst_rdata",   axi.rdata,        32'd0);
    chk("rst_wstate",  32'(dut.wstate),  32'd3);
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rel_awready", 32'(axi.awready), 32'd1);
    chk("rel_arready", 32'(axi.arready), 32'd1);

    // Full-word writes and readback
    axi_write(12'h010, 32'h11111111, 4'hF, 0);
    axi_write(12'h018, 32'h22222222, 4'hF, 0);
    axi_write(12'h020, 32'h33333333, 4'hF, 0);
    axi_read(12'h010, 32'h11111111, 0);
    axi_read(12'h018, 32'h22222222, 0);
    axi_read(12'h020, 32'h33333333, 0);

    // Partial strobe into a zeroed register
    axi_write(12'h028, 32'hAABBCCDD, 4'b0101, 0);
    axi_read(12'h028, 32'h00BB00DD, 0);

    // Zero strobe leaves the register unchanged
    axi_write(12'h028, 32'h12345678, 4'b0000, 0);
    axi_read(12'h028, 32'h00BB00DD, 0);

    // Unmapped address
    axi_write(12'h100, 32'hDEADBEEF, 4'hF, 0);
    axi_read(12'h100, 32'h00000000, 0);
    axi_read(12'h010, 32'h11111111, 0);

    // Back-pressure on B and R
    axi_write(12'h020, 32'h5A5A5A5A, 4'hF, 5);
    axi_read(12'h020, 32'h5A5A5A5A, 5);

    // Write and read of REG0 on the same edge: read sees the old value
    @(negedge ap_clk);
    axi.awaddr = 12'h010; axi.awvalid = 1'b1;
    @(posedge ap_clk); #1 axi.awvalid = 1'b0;
    @(negedge ap_clk);
    chk("coll_wready", 32'(axi.wready), 32'd1);
    axi.wdata = 32'h44444444; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    axi.araddr = 12'h010; axi.arvalid = 1'b1;
    @(posedge ap_clk); #1 axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    @(negedge ap_clk);
    chk("coll_bvalid", 32'(axi.bvalid), 32'd1);
    chk("coll_rvalid", 32'(axi.rvalid), 32'd1);
    chk("coll_rdata_old", axi.rdata, 32'h11111111);
    axi.bready = 1'b1; axi.rready = 1'b1;
    @(posedge ap_clk); #1 axi.bready = 1'b0; axi.rready = 1'b0;
    axi_read(12'h010, 32'h44444444, 0);

    // Reset while in WR_DATA with wvalid asserted
    @(negedge ap_clk);
    axi.awaddr = 12'h018; axi.awvalid = 1'b1;
    @(posedge ap_clk); #1 axi.awvalid = 1'b0;
    @(negedge ap_clk);
    chk("abort_wstate_data", 32'(dut.wstate), 32'd1);
    axi.wdata = 32'hFFFFFFFF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    ap_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("abort_bvalid_rst", 32'(axi.bvalid), 32'd0);
    end
    chk("abort_wstate_rst", 32'(dut.wstate), 32'd3);
    @(posedge ap_clk); #1 ap_rst = 1'b0; axi.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("abort_bvalid_rel", 32'(axi.bvalid), 32'd0);
    end
    axi_read(12'h018, 32'h00000000, 0);
    axi_read(12'h010, 32'h00000000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
